// File: rtl/trap_request_arbiter.sv
// trap_request_arbiter: shares the CSR trap-entry port between NUM_REQ lanes.
// Lane 0 has priority (bounded by a streak limiter); lanes 1.. are round-robin.
module trap_request_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_HI_STREAK = 3,
  parameter int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_mcause,
  output logic [NUM_REQ-1:0]    req_ack,
  input  logic                  csr_busy,
  input  logic                  int_taken,
  output logic                  int_valid,
  output logic [31:0]           int_mcause,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [7:0]            withdraw_cnt
);
  localparam int HS_W = ($clog2(MAX_HI_STREAK + 1) > 0) ? $clog2(MAX_HI_STREAK + 1) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t              state_q, state_d;
  logic                int_valid_q, int_valid_d;
  logic [31:0]         int_mcause_q, int_mcause_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [7:0]          withdraw_cnt_q, withdraw_cnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HS_W-1:0]     hi_streak_q, hi_streak_d;
  logic                others, rr_hit, hi_win;
  logic [IDX_W-1:0]    rr_idx, win_idx;
  int                  lane;
  // Round-robin search over lanes 1..NUM_REQ-1 starting at rr_ptr, wrapping to 1.
  always_comb begin
    others = |req_valid[NUM_REQ-1:1];
    rr_hit = 1'b0;
    rr_idx = '0;
    lane   = 0;
    for (int o = 0; o < NUM_REQ - 1; o++) begin
      lane = ((int'(rr_ptr_q) - 1 + o) % (NUM_REQ - 1)) + 1;
      if (!rr_hit && req_valid[lane]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(lane);
      end
    end
    hi_win  = req_valid[0] && !(hi_streak_q == HS_W'(MAX_HI_STREAK) && others);
    win_idx = hi_win ? '0 : rr_idx;
  end
  always_comb begin
    state_d        = state_q;
    int_valid_d    = int_valid_q;
    int_mcause_d   = int_mcause_q;
    req_ack_d      = '0;
    grant_idx_d    = grant_idx_q;
    withdraw_cnt_d = withdraw_cnt_q;
    rr_ptr_d       = rr_ptr_q;
    hi_streak_d    = hi_streak_q;
    case (state_q)
      IDLE: if (!csr_busy && |req_valid) begin
        state_d      = GRANT;
        int_valid_d  = 1'b1;
        grant_idx_d  = win_idx;
        int_mcause_d = req_mcause[32*int'(win_idx) +: 32];
      end
      GRANT: if (int_taken) begin
        state_d                = ACK;
        int_valid_d            = 1'b0;
        req_ack_d[grant_idx_q] = 1'b1;
        if (grant_idx_q != '0) begin
          rr_ptr_d    = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : grant_idx_q + 1'b1;
          hi_streak_d = '0;
        end else
          hi_streak_d = !others ? '0 :
                        (hi_streak_q == HS_W'(MAX_HI_STREAK)) ? hi_streak_q : hi_streak_q + 1'b1;
      end else if (!req_valid[grant_idx_q] || csr_busy) begin
        state_d        = IDLE;
        int_valid_d    = 1'b0;
        withdraw_cnt_d = (withdraw_cnt_q == 8'hff) ? withdraw_cnt_q : withdraw_cnt_q + 1'b1;
      end
      ACK: state_d = IDLE;
      default: begin
        state_d     = IDLE;
        int_valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      int_valid_q    <= 1'b0;
      int_mcause_q   <= '0;
      req_ack_q      <= '0;
      grant_idx_q    <= '0;
      withdraw_cnt_q <= '0;
      rr_ptr_q       <= IDX_W'(1);
      hi_streak_q    <= '0;
    end else begin
      state_q        <= state_d;
      int_valid_q    <= int_valid_d;
      int_mcause_q   <= int_mcause_d;
      req_ack_q      <= req_ack_d;
      grant_idx_q    <= grant_idx_d;
      withdraw_cnt_q <= withdraw_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      hi_streak_q    <= hi_streak_d;
    end
  end
  assign int_valid    = int_valid_q;
  assign int_mcause   = int_mcause_q;
  assign req_ack      = req_ack_q;
  assign grant_idx    = grant_idx_q;
  assign withdraw_cnt = withdraw_cnt_q;
endmodule

// File: tb/tb_trap_request_arbiter.sv
// tb_trap_request_arbiter: directed scoreboard bench for trap_request_arbiter.
module tb_trap_request_arbiter;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_mcause = {32'd103, 32'd15, 32'd101, 32'd100};
  logic [3:0]   req_ack;
  logic         csr_busy = 1'b0;
  logic         int_taken = 1'b0;
  logic         int_valid;
  logic [31:0]  int_mcause;
  logic [1:0]   grant_idx;
  logic [7:0]   withdraw_cnt;
  typedef struct {
    logic [1:0]  idx;
    logic [31:0] mc;
  } exp_t;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] last_idx = '0;
  trap_request_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_mcause(req_mcause),
    .req_ack(req_ack), .csr_busy(csr_busy), .int_taken(int_taken),
    .int_valid(int_valid), .int_mcause(int_mcause), .grant_idx(grant_idx),
    .withdraw_cnt(withdraw_cnt)
  );
  always #5 clk = ~clk;
  // Per-cycle invariants: ack one-hot or zero and never alongside int_valid.
  always @(negedge clk) if (!reset) begin
    checks++;
    assert ($onehot0(req_ack) && !(|req_ack && int_valid)) else begin
      errors++;
      $error("FAIL ack_invariant obs ack=%b valid=%b exp onehot0 and exclusive", req_ack, int_valid);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [1:0] idx);
    exp_t e;
    e.idx = idx;
    e.mc  = req_mcause[32*idx +: 32];
    sb.push_back(e);
  endtask
  task automatic wait_grant;
    exp_t e;
    int   n = 0;
    while (int_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_timeout", {31'd0, int_valid}, 32'd1);
    e = sb.pop_front();
    chk("grant_idx", {30'd0, grant_idx}, {30'd0, e.idx});
    chk("int_mcause", int_mcause, e.mc);
    last_idx = e.idx;
  endtask
  task automatic take(input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << last_idx;
    int_taken = 1'b1;
    tick();
    chk("ack", {28'd0, req_ack}, {28'd0, oh});
    chk("valid_after_take", {31'd0, int_valid}, 32'd0);
    int_taken = 1'b0;
    if (drop) req_valid[last_idx] = 1'b0;
    tick();
    chk("ack_clear", {28'd0, req_ack}, 32'd0);
  endtask
  task automatic do_reset;
    req_valid = '0;
    int_taken = 1'b0;
    csr_busy  = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", {31'd0, int_valid}, 32'd0);
    chk("rst_mcause", int_mcause, 32'd0);
    chk("rst_ack", {28'd0, req_ack}, 32'd0);
    chk("rst_idx", {30'd0, grant_idx}, 32'd0);
    chk("rst_wcnt", {24'd0, withdraw_cnt}, 32'd0);
    reset = 1'b0;
    tick();
    // Single lane, one-cycle latency
    req_valid = 4'b0100;
    push(2'd2);
    tick();
    chk("single_latency", {31'd0, int_valid}, 32'd1);
    wait_grant();
    chk("single_mcause15", int_mcause, 32'd15);
    take(1'b1);
    // Round-robin among lanes 1..3
    do_reset();
    req_valid = 4'b1110;
    push(2'd1); push(2'd2); push(2'd3); push(2'd1);
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      take(1'b0);
    end
    // Starvation guard with lanes 0 and 2
    do_reset();
    req_valid = 4'b0101;
    push(2'd0); push(2'd0); push(2'd0); push(2'd2);
    push(2'd0); push(2'd0); push(2'd0); push(2'd2);
    for (int i = 0; i < 8; i++) begin
      wait_grant();
      take(1'b0);
    end
    // Withdraw on csr_busy, then re-grant
    do_reset();
    req_valid = 4'b0010;
    push(2'd1);
    wait_grant();
    csr_busy = 1'b1;
    tick();
    chk("wd_valid", {31'd0, int_valid}, 32'd0);
    chk("wd_ack", {28'd0, req_ack}, 32'd0);
    chk("wd_cnt", {24'd0, withdraw_cnt}, 32'd1);
    tick();
    chk("busy_hold", {31'd0, int_valid}, 32'd0);
    csr_busy = 1'b0;
    push(2'd1);
    wait_grant();
    take(1'b1);
    // Simultaneous int_taken and csr_busy: ack wins
    req_valid = 4'b1000;
    push(2'd3);
    wait_grant();
    int_taken = 1'b1;
    csr_busy  = 1'b1;
    tick();
    chk("tb_ack", {28'd0, req_ack}, 32'h8);
    chk("tb_cnt", {24'd0, withdraw_cnt}, 32'd1);
    int_taken = 1'b0;
    csr_busy  = 1'b0;
    req_valid = 4'b0000;
    tick();
    // Requester drops during GRANT
    req_valid = 4'b0010;
    push(2'd1);
    wait_grant();
    req_valid = 4'b0000;
    tick();
    chk("drop_valid", {31'd0, int_valid}, 32'd0);
    chk("drop_ack", {28'd0, req_ack}, 32'd0);
    chk("drop_cnt", {24'd0, withdraw_cnt}, 32'd2);
    tick();
    // Asynchronous reset between edges, mid-GRANT
    req_valid = 4'b1000;
    push(2'd3);
    wait_grant();
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", {31'd0, int_valid}, 32'd0);
    chk("async_ack", {28'd0, req_ack}, 32'd0);
    chk("async_wcnt", {24'd0, withdraw_cnt}, 32'd0);
    tick();
    chk("async_ack_hold", {28'd0, req_ack}, 32'd0);
    reset = 1'b0;
    req_valid = 4'b1110;
    push(2'd1);
    wait_grant();
    take(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
